mda_periph_reset_seq: RTL

Parametrised power-up reset sequencer for the sub's peripherals (IMU, sonar front-ends, spare boards), driven by the power-management kill switch.
- On a debounced rising edge of the kill-switch power signal, issues one fixed-width active-high reset pulse to each enabled channel, in index order, with a programmable gap between pulses.
- After the sequence, software or a supervisor can request an on-demand reset pulse for any single channel.
- Instantiated in the top level between the power-management output and the peripheral reset pins.

---
 rtl/mda_pkg.sv | 24 ++
 rtl/mda_debounce.sv | 47 ++++
 rtl/mda_periph_reset_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mda_pkg.sv
// Shared types for the MDA reset sequencer family: FSM state encoding and a
// lowest-set-bit priority pick used to walk channel masks in index order.
package mda_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned CH_W   = 4;

  typedef enum logic [2:0] {
    OFF,
    PULSE,
    GAP,
    ON,
    MANUAL
  } seq_state_e;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [CH_W-1:0] lowest_set(input logic [MAX_CH-1:0] v);
    lowest_set = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/mda_debounce.sv
// Two-flop synchroniser followed by a per-bit debounce counter; the output
// toggles only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
import mda_pkg::*;

module mda_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q;
  logic [CW-1:0]    cnt_q [WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= ~stable_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/mda_periph_reset_seq.sv
// Power-up reset sequencer: one pulse per enabled channel in index order with
// a gap between pulses, then on-demand single-channel pulses while powered.
import mda_pkg::*;

module mda_periph_reset_seq #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned PULSE_CYCLES    = 100,
  parameter int unsigned STAGGER_CYCLES  = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              power_in,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] manual_req,
  output logic [NUM_CH-1:0] periph_reset,
  output logic              power_good,
  output logic              busy,
  output logic              seq_done
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGGER_CYCLES - 1);

  logic              pg;
  seq_state_e        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pend_q, pend_d, clr;
  logic [NUM_CH-1:0] periph_q, periph_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MAX_CH-1:0] en_in_w, above_w, pend_w;

  mda_debounce #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (power_in),
    .stable_o (pg)
  );

  // Masks widened to the priority function's fixed width.
  always_comb begin
    en_in_w = '0;
    above_w = '0;
    pend_w  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      en_in_w[i] = ch_enable[i];
      above_w[i] = en_q[i] && (i > int'(ch_q));
      pend_w[i]  = pend_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    en_d    = en_q;
    tmr_d   = tmr_q;
    clr     = '0;
    case (state_q)
      // OFF is only entered with power_good low, so seeing it high here is the rising edge.
      OFF: begin
        if (pg) begin
          en_d    = ch_enable;
          ch_d    = lowest_set(en_in_w);
          tmr_d   = '0;
          state_d = (ch_enable == '0) ? ON : PULSE;
        end
      end
      PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          tmr_d = '0;
          if (above_w != '0) begin
            state_d = GAP;
            ch_d    = lowest_set(above_w);
          end else begin
            state_d = ON;
          end
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = PULSE;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ON: begin
        if (pend_q != '0) begin
          ch_d    = lowest_set(pend_w);
          clr     = NUM_CH'(1) << ch_d;
          tmr_d   = '0;
          state_d = MANUAL;
        end
      end
      MANUAL: begin
        if (tmr_q == PULSE_LAST) begin
          tmr_d   = '0;
          state_d = ON;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase

    if (!pg) begin
      state_d = OFF;
      tmr_d   = '0;
    end

    pend_d   = pg ? ((pend_q | manual_req) & ~clr) : '0;
    periph_d = (state_d == PULSE || state_d == MANUAL) ? (NUM_CH'(1) << ch_d) : '0;
    busy_d   = (state_d == PULSE) || (state_d == GAP) || (state_d == MANUAL);
    done_d   = (state_d == ON) || (state_d == MANUAL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= OFF;
      ch_q     <= '0;
      en_q     <= '0;
      tmr_q    <= '0;
      pend_q   <= '0;
      periph_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      en_q     <= en_d;
      tmr_q    <= tmr_d;
      pend_q   <= pend_d;
      periph_q <= periph_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign periph_reset = periph_q;
  assign power_good   = pg;
  assign busy         = busy_q;
  assign seq_done     = done_q;

endmodule
